// File: rtl/pattern_scan_if.sv
// pattern_scan_if: requester words in, scan results out, between word sources and the shared scan engine.
interface pattern_scan_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(DATA_W + 1);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    res_valid;
  logic                    res_ready;
  logic [ID_W-1:0]         res_id;
  logic [CNT_W-1:0]        res_count;
  logic                    res_last_hit;
  logic                    busy;
  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_count, res_last_hit, busy
  );
  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_count, res_last_hit, busy
  );
endinterface

// File: rtl/pattern_scan_arbiter.sv
// pattern_scan_arbiter: round-robin picks one requester word and shifts it MSB-first
// through a single time-shared Moore "101" detector, returning hit count and last-bit hit.
module pattern_scan_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  pattern_scan_if.slave bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

  state_t            state_q, state_d;
  det_t              det_q, det_d, det_nx;
  logic [ID_W-1:0]   ptr_q, ptr_d, id_q, id_d, gnt_idx, cand;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, bit_q, bit_d;
  logic              any_valid, accept;

  // Scan downward from the farthest candidate so the one closest to ptr wins.
  always_comb begin
    any_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (bus.req_valid[cand]) begin
        any_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Gated by rst_n so no grant is offered while reset is held.
  assign accept        = any_valid && state_q == IDLE && rst_n;
  assign bus.req_ready = accept ? N_REQ'(1) << gnt_idx : '0;
  assign det_nx        = sh_q[DATA_W-1] ? (det_q == S2 ? S3 : S1) : (det_q == S1 ? S2 : S0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sh_d    = sh_q;
    det_d   = det_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SHIFT;
        ptr_d   = gnt_idx == ID_W'(N_REQ - 1) ? '0 : gnt_idx + 1'b1;
        id_d    = gnt_idx;
        sh_d    = bus.req_data[gnt_idx*DATA_W +: DATA_W];
        det_d   = S0;
        cnt_d   = '0;
        bit_d   = '0;
      end
      SHIFT: begin
        sh_d    = sh_q << 1;
        det_d   = det_nx;
        cnt_d   = (det_nx == S3 && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        bit_d   = bit_q + 1'b1;
        state_d = bit_q == CNT_W'(DATA_W - 1) ? DONE : SHIFT;
      end
      DONE:    state_d = bus.res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      sh_q    <= '0;
      det_q   <= S0;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sh_q    <= sh_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  assign bus.res_valid    = state_q == DONE;
  assign bus.busy         = state_q != IDLE;
  assign bus.res_id       = id_q;
  assign bus.res_count    = cnt_q;
  assign bus.res_last_hit = det_q == S3;
endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// tb_pattern_scan_arbiter: directed vector table, arbitration/reset sequences and
// randomized jobs checked against a pattern-level reference of the scan engine.
module tb_pattern_scan_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pattern_scan_if #(.N_REQ(N), .DATA_W(W)) bus();
  pattern_scan_arbiter #(.N_REQ(N), .DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [N-1:0][W-1:0] words;
  assign bus.req_data = words;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ptr_m   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [7:0] word;
    int         cnt;
    bit         last;
    int         hold;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    words = '0;
    ptr_m = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // A "101" ends at bit k unless its leading 1 was the closing 1 of a hit at k-2.
  function automatic void ref_scan(input logic [W-1:0] w, output int cnt, output bit last);
    bit b[W];
    bit h[W];
    cnt = 0;
    for (int k = 0; k < W; k++) begin
      b[k] = w[W-1-k];
      h[k] = 1'b0;
      if (k >= 2) h[k] = b[k-2] && !b[k-1] && b[k] && !h[k-2];
      cnt += int'(h[k]);
    end
    last = h[W-1];
  endfunction

  task automatic chk_result(input int id, input int cnt, input bit last);
    chk("res_valid", 32'(bus.res_valid), 1);
    chk("res_id", 32'(bus.res_id), id);
    chk("res_count", 32'(bus.res_count), cnt);
    chk("res_last_hit", 32'(bus.res_last_hit), 32'(last));
  endtask

  task automatic run_job(input vec_t v);
    words[v.id] = v.word;
    bus.req_valid = '0;
    bus.req_valid[v.id] = 1'b1;
    bus.res_ready = v.hold == 0;
    #1 chk("accept_ready", 32'(bus.req_ready), 1 << v.id);
    tick;
    bus.req_valid = '0;
    words[v.id] = ~v.word;
    for (int k = 1; k <= W; k++) begin
      chk("shift_res_valid", 32'(bus.res_valid), 0);
      chk("shift_busy", 32'(bus.busy), 1);
      tick;
    end
    for (int h = 0; h < v.hold; h++) begin
      bus.req_valid = '1;
      #1 chk("hold_no_grant", 32'(bus.req_ready), 0);
      chk_result(v.id, v.cnt, v.last);
      tick;
    end
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    #1 chk_result(v.id, v.cnt, v.last);
    tick;
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_res_valid", 32'(bus.res_valid), 0);
  endtask

  task automatic scan(input int jobs, input logic [N-1:0] mask, input bit keep, input bit rnd);
    logic [N-1:0] v;
    logic [W-1:0] w;
    int pick, waited, hold, last_t, ecnt, idx;
    bit elast;
    v = mask;
    last_t = -1;
    for (int j = 0; j < jobs; j++) begin
      waited = 0;
      pick = -1;
      while (1) begin
        if (rnd)
          for (int i = 0; i < N; i++)
            if (!v[i] && $urandom_range(0, 2) == 0) begin
              v[i] = 1'b1;
              words[i] = W'($urandom);
            end
        bus.req_valid = v;
        #1;
        pick = -1;
        for (int k = 0; k < N; k++) begin
          idx = (ptr_m + k) % N;
          if (v[idx] && pick < 0) pick = idx;
        end
        chk("grant", 32'(bus.req_ready), pick < 0 ? 0 : 1 << pick);
        if (pick >= 0 || waited == 30) break;
        tick;
        waited++;
      end
      if (pick < 0) begin
        chk("grant_timeout", 0, 1);
        return;
      end
      if (keep && last_t >= 0) chk("accept_spacing", cyc - last_t, W + 2);
      last_t = cyc;
      w = words[pick];
      ptr_m = (pick + 1) % N;
      ref_scan(w, ecnt, elast);
      hold = rnd ? $urandom_range(0, 3) : 0;
      tick;
      if (!keep) v[pick] = 1'b0;
      if (rnd) words[pick] = W'($urandom);
      for (int k = 1; k <= W; k++) begin
        bus.req_valid = v;
        if (rnd) bus.res_ready = 1'($urandom);
        #1 chk("shift_no_grant", 32'(bus.req_ready), 0);
        chk("shift_res_valid", 32'(bus.res_valid), 0);
        tick;
      end
      bus.res_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        #1 chk("done_no_grant", 32'(bus.req_ready), 0);
        chk_result(pick, ecnt, elast);
        tick;
      end
      bus.res_ready = 1'b1;
      #1 chk_result(pick, ecnt, elast);
      chk("done_no_grant", 32'(bus.req_ready), 0);
      tick;
    end
    bus.req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 8'hA5, 2, 1'b1, 0};
    tbl[1] = '{2, 8'hB6, 2, 1'b0, 0};
    tbl[2] = '{1, 8'h54, 1, 1'b0, 0};
    tbl[3] = '{3, 8'hFF, 0, 1'b0, 0};
    tbl[4] = '{1, 8'hAD, 2, 1'b1, 5};
    tbl[5] = '{0, 8'h00, 0, 1'b0, 0};
    tbl[6] = '{2, 8'h15, 1, 1'b0, 2};

    bus.req_valid = '1;
    bus.res_ready = 1'b0;
    words = '0;
    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    do_reset;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_id", 32'(bus.res_id), 0);
    chk("rst_res_count", 32'(bus.res_count), 0);
    chk("rst_res_last_hit", 32'(bus.res_last_hit), 0);
    chk("rst_req_ready_idle", 32'(bus.req_ready), 0);

    foreach (tbl[i]) run_job(tbl[i]);

    do_reset;
    bus.res_ready = 1'b1;
    scan(5, 4'b1111, 1'b1, 1'b0);
    do_reset;
    bus.res_ready = 1'b1;
    scan(4, 4'b1010, 1'b1, 1'b0);

    // Reset in the 4th shift cycle drops the job and every output at once.
    do_reset;
    words[2] = 8'hA5;
    bus.req_valid = 4'b0100;
    bus.res_ready = 1'b1;
    #1 chk("mid_accept", 32'(bus.req_ready), 4);
    tick;
    bus.req_valid = '0;
    repeat (3) tick;
    chk("mid_busy", 32'(bus.busy), 1);
    bus.req_valid = 4'b1100;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_res_valid", 32'(bus.res_valid), 0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 0);
    chk("mid_rst_res_id", 32'(bus.res_id), 0);
    chk("mid_rst_res_count", 32'(bus.res_count), 0);
    chk("mid_rst_res_last_hit", 32'(bus.res_last_hit), 0);
    repeat (2) begin
      tick;
      chk("mid_rst_no_result", 32'(bus.res_valid), 0);
    end
    rst_n = 1'b1;
    #1 chk("post_rst_grant", 32'(bus.req_ready), 4);

    do_reset;
    scan(40, 4'b0000, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
